// File: rtl/proc_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the
// 8-bit accumulator processor.
package proc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_ctrl_seq_if.sv
// Instruction handshake plus register-file bus of the sequencer.
// master = instruction source / register file side, slave = sequencer.
interface acc_ctrl_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic [7:0]        instr_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata;

  modport master (
    output instr_data,
    output instr_valid,
    input  instr_ready,
    input  rf_addr,
    input  rf_wdata,
    input  rf_we,
    output rf_rdata
  );

  modport slave (
    input  instr_data,
    input  instr_valid,
    output instr_ready,
    output rf_addr,
    output rf_wdata,
    output rf_we,
    input  rf_rdata
  );

endinterface

// File: rtl/acc_alu.sv
// Combinational ALU of the accumulator machine.
// Multiply path exists only when ACC_CTRL_MUL_EN is defined.
module acc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic              carry_out
);

`ifdef ACC_CTRL_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, rdata};
`endif

  always_comb begin
    result    = rdata;
    result_hi = '0;
    carry_out = 1'b0;
    unique case (op)
      OP_ADD: {carry_out, result} = {1'b0, acc} + {1'b0, rdata};
      OP_SUB: begin
        result    = acc - rdata;
        carry_out = (acc < rdata);
      end
      OP_AND: result = acc & rdata;
      OP_OR:  result = acc | rdata;
      OP_XOR: result = acc ^ rdata;
`ifdef ACC_CTRL_MUL_EN
      OP_MUL: begin
        {result_hi, result} = prod;
        carry_out = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_ctrl_seq.sv
// Fetch/execute sequencer driving a single-port register file.
// ACC_CTRL_MUL_EN enables opcode 9 (MUL) and the acc_hi register.
module acc_ctrl_seq
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  acc_ctrl_seq_if.slave     bus,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] acc_hi,
  output logic              carry,
  output logic              zero,
  output logic              busy,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [7:0]        ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;

  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] alu_hi;
  logic              alu_c;
  logic [DATA_W-1:0] wr_val;
  logic              acc_wr;
  logic              sta_we;

  assign op  = ir_q[7:4];
  assign imm = {{(DATA_W-4){1'b0}}, ir_q[3:0]};

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (op),
    .acc      (acc_q),
    .rdata    (bus.rf_rdata),
    .result   (alu_res),
    .result_hi(alu_hi),
    .carry_out(alu_c)
  );

`ifdef ACC_CTRL_MUL_EN
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
`endif

  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    acc_d           = acc_q;
    carry_d         = carry_q;
    zero_d          = zero_q;
`ifdef ACC_CTRL_MUL_EN
    acc_hi_d        = acc_hi_q;
`endif
    wr_val          = alu_res;
    acc_wr          = 1'b0;
    sta_we          = 1'b0;
    bus.instr_ready = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          ir_d    = bus.instr_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        unique case (1'b1)
          (op == OP_LDA): acc_wr = 1'b1;
          (op == OP_STA): sta_we = 1'b1;
          (op inside {OP_ADD, OP_SUB}): begin
            acc_wr  = 1'b1;
            carry_d = alu_c;
          end
          (op inside {OP_AND, OP_OR, OP_XOR}): begin
            acc_wr  = 1'b1;
            carry_d = 1'b0;
          end
          (op == OP_LDI): begin
            acc_wr = 1'b1;
            wr_val = imm;
          end
`ifdef ACC_CTRL_MUL_EN
          (op == OP_MUL): begin
            acc_wr   = 1'b1;
            carry_d  = alu_c;
            acc_hi_d = alu_hi;
          end
`endif
          (op == OP_HLT): state_d = ST_HALT;
          default: ;
        endcase
        if (acc_wr) begin
          acc_d  = wr_val;
          zero_d = (wr_val == '0);
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
`ifdef ACC_CTRL_MUL_EN
      acc_hi_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
`ifdef ACC_CTRL_MUL_EN
      acc_hi_q <= acc_hi_d;
`endif
    end
  end

  // A store still in EXEC when rst rises must not reach the register file
  assign bus.rf_we    = sta_we & ~rst;
  assign bus.rf_addr  = ir_q[ADDR_W-1:0];
  assign bus.rf_wdata = acc_q;

  assign acc    = acc_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign busy   = (state_q == ST_EXEC);
  assign halted = (state_q == ST_HALT);

`ifdef ACC_CTRL_MUL_EN
  assign acc_hi = acc_hi_q;
`else
  assign acc_hi = alu_hi;
`endif

endmodule
